// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types, fetch FSM encoding and pipeline constants
package core_pkg;

    // Fetch FSM: IDLE waits for permission to issue, REQ holds a request
    // until granted, WAIT holds until the single outstanding read returns.
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2
    } fetch_state_e;

    // addi x0, x0, 0 -- placed in decode whenever the slot holds no instruction
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Operand forwarding selects shared with decode/execute
    localparam logic [1:0] Forward_RF  = 2'b00;
    localparam logic [1:0] Forward_WB  = 2'b01;
    localparam logic [1:0] Forward_MEM = 2'b10;

    // Branch types (funct3 encodings) shared with the branch/jump unit
    localparam logic [2:0] Branch_BEQ  = 3'b000;
    localparam logic [2:0] Branch_BNE  = 3'b001;
    localparam logic [2:0] Branch_BLT  = 3'b100;
    localparam logic [2:0] Branch_BGE  = 3'b101;
    localparam logic [2:0] Branch_BLTU = 3'b110;
    localparam logic [2:0] Branch_BGEU = 3'b111;

    // Sequential fetch advances one word; 32-bit wrap is intended
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry instruction+PC holding buffer for fetch
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] load_data,
    input  logic [31:0] load_pc,
    output logic        full,
    output logic [31:0] data,
    output logic [31:0] pc
);

    // Occupancy: clear wins, a load refills even while the old entry drains
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

    // Payload capture; contents are only meaningful while full is set
    always_ff @(posedge clk) begin
        if (load) begin
            data <= load_data;
            pc   <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch PC generator, imem request FSM and IF/ID register
module fetch_pc_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_src_D,
    input  logic [31:0] PC_Target_D,
    input  logic        stall_F,
    input  logic        stall_D,
    input  logic        flush_D,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_F,
    output logic [31:0] instr_D,
    output logic [31:0] PC_D,
    output logic        valid_D
);

    fetch_state_e state;
    logic [31:0]  pc_f_q;
    logic [31:0]  req_addr_q;
    logic         drop_q;

    logic         redirect;
    logic         rsp_take;
    logic         deliver;
    logic         if_id_open;
    logic         skid_full;
    logic         skid_load;
    logic         skid_drain;
    logic         skid_full_next;
    logic [31:0]  skid_data;
    logic [31:0]  skid_pc;
    logic [31:0]  resume_pc;
    logic         resume_go;

    // A redirect only counts when decode holds a real instruction that moves on
    assign redirect   = PC_src_D & valid_D & ~stall_D;

    // Read data is only accepted while the single request is outstanding
    assign rsp_take   = (state == FETCH_WAIT) & imem_rvalid;

    // A response arriving together with a redirect is wrong-path, so it is
    // discarded here instead of arming drop for a response that never comes
    assign deliver    = rsp_take & ~drop_q & ~redirect;

    // IF/ID accepts new content only when neither held nor flushed
    assign if_id_open = ~stall_D & ~flush_D;

    // The buffered entry is older than any new response, so it drains first
    // and a response that cannot go straight into IF/ID parks in the buffer
    assign skid_drain     = skid_full & if_id_open & ~redirect;
    assign skid_load      = deliver & (~if_id_open | skid_full);
    assign skid_full_next = skid_load | (skid_full & ~skid_drain & ~redirect);

    // PC to continue from after this cycle: redirect target, next word after
    // a delivery, otherwise unchanged (also the replay PC after a discard)
    always_comb begin
        resume_pc = pc_f_q;
        if (redirect) begin
            resume_pc = PC_Target_D;
        end else if (deliver) begin
            resume_pc = next_seq_pc(pc_f_q);
        end
    end

    // New request only when fetch is not stalled and there is room for its data
    assign resume_go = ~stall_F & ~skid_full_next;

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .drain     (skid_drain),
        .clear     (redirect),
        .load_data (imem_rdata),
        .load_pc   (pc_f_q),
        .full      (skid_full),
        .data      (skid_data),
        .pc        (skid_pc)
    );

    // Fetch FSM: PC_F, request address, and the drop flag for a killed fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH_IDLE;
            pc_f_q     <= RESET_PC;
            req_addr_q <= RESET_PC;
            drop_q     <= 1'b0;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (redirect) begin
                        pc_f_q <= PC_Target_D;
                    end
                    // a redirect empties the buffer, so only stall_F can defer it
                    if (~stall_F && (redirect || ~skid_full)) begin
                        state      <= FETCH_REQ;
                        req_addr_q <= resume_pc;
                    end
                end
                FETCH_REQ: begin
                    // the request already on the bus stays as issued; its data
                    // will be thrown away and the target fetched afterwards
                    if (redirect) begin
                        pc_f_q <= PC_Target_D;
                        drop_q <= 1'b1;
                    end
                    if (imem_gnt) begin
                        state <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_rvalid) begin
                        pc_f_q <= resume_pc;
                        drop_q <= 1'b0;
                        if (resume_go) begin
                            state      <= FETCH_REQ;
                            req_addr_q <= resume_pc;
                        end else begin
                            state <= FETCH_IDLE;
                        end
                    end else if (redirect) begin
                        // stays set if already set: only one response is in flight
                        pc_f_q <= PC_Target_D;
                        drop_q <= 1'b1;
                    end
                end
                default: begin
                    state <= FETCH_IDLE;
                end
            endcase
        end
    end

    // IF/ID register: flush beats stall, buffered entry beats new response
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_D <= 1'b0;
            instr_D <= NOP_INSTR;
            PC_D    <= 32'h0000_0000;
        end else if (flush_D) begin
            valid_D <= 1'b0;
            instr_D <= NOP_INSTR;
        end else if (~stall_D) begin
            if (redirect) begin
                valid_D <= 1'b0;
                instr_D <= NOP_INSTR;
            end else if (skid_full) begin
                valid_D <= 1'b1;
                instr_D <= skid_data;
                PC_D    <= skid_pc;
            end else if (deliver) begin
                valid_D <= 1'b1;
                instr_D <= imem_rdata;
                PC_D    <= pc_f_q;
            end else begin
                valid_D <= 1'b0;
                instr_D <= NOP_INSTR;
            end
        end
    end

    assign imem_req  = (state == FETCH_REQ);
    assign imem_addr = req_addr_q;
    assign PC_F      = pc_f_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed scoreboard bench for fetch_pc_unit
module tb_fetch_pc_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        PC_src_D;
    logic [31:0] PC_Target_D;
    logic        stall_F;
    logic        stall_D;
    logic        flush_D;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] PC_F;
    logic [31:0] instr_D;
    logic [31:0] PC_D;
    logic        valid_D;

    fetch_pc_unit dut (
        .clk         (clk),
        .rst         (rst),
        .PC_src_D    (PC_src_D),
        .PC_Target_D (PC_Target_D),
        .stall_F     (stall_F),
        .stall_D     (stall_D),
        .flush_D     (flush_D),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .PC_F        (PC_F),
        .instr_D     (instr_D),
        .PC_D        (PC_D),
        .valid_D     (valid_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_pc[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    bit          pend     = 1'b0;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          lat      = 1;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: score accepted requests and newly loaded IF/ID entries, then
    // drive the memory response for the next cycle
    task automatic cycle();
        logic        acc;
        logic [31:0] a;
        logic        open;
        logic [31:0] e;
        acc  = imem_req && imem_gnt && !rst;
        a    = imem_addr;
        open = !stall_D && !flush_D && !rst;
        @(posedge clk);
        #1;
        if (acc) begin
            chk1("req_expected", exp_addr.size() != 0, 1'b1);
            if (exp_addr.size() != 0) begin
                e = exp_addr.pop_front();
                chk("imem_addr", a, e);
            end
            pend      = 1'b1;
            pend_addr = a;
            pend_cnt  = lat;
        end
        if (open && valid_D) begin
            chk1("instr_expected", exp_pc.size() != 0, 1'b1);
            if (exp_pc.size() != 0) begin
                e = exp_pc.pop_front();
                chk("PC_D", PC_D, e);
                chk("instr_D", instr_D, memf(e));
            end
        end
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (pend) begin
            if (pend_cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memf(pend_addr);
                pend        = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
    endtask

    // Run until every queued address is accepted, then stall fetch and run
    // until every queued instruction has reached decode
    task automatic drain_fetch(input string tag);
        int n;
        n = 0;
        while (exp_addr.size() != 0 && n < 60) begin
            cycle();
            n++;
        end
        stall_F = 1'b1;
        while (exp_pc.size() != 0 && n < 60) begin
            cycle();
            n++;
        end
        chk1({tag, "_budget"}, n < 60, 1'b1);
    endtask

    initial begin
        int n;
        rst = 1'b1; PC_src_D = 1'b0; PC_Target_D = 32'h0; stall_F = 1'b0;
        stall_D = 1'b0; flush_D = 1'b0; imem_gnt = 1'b1;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;

        // reset state
        cycle();
        cycle();
        chk("rst_PC_F", PC_F, 32'h0);
        chk1("rst_imem_req", imem_req, 1'b0);
        chk1("rst_valid_D", valid_D, 1'b0);
        chk("rst_instr_D", instr_D, NOP);
        chk("rst_PC_D", PC_D, 32'h0);

        // sequential fetch 0..3
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_addr.push_back(32'(i));
            exp_pc.push_back(32'(i));
        end
        drain_fetch("p1");
        cycle();
        chk1("p1_idle_req", imem_req, 1'b0);
        chk1("p1_bubble", valid_D, 1'b0);
        chk("p1_PC_F", PC_F, 32'h4);

        // addr 5 returns while decode is stalled: parked, no new request
        stall_F = 1'b0;
        for (int i = 4; i < 7; i++) begin
            exp_addr.push_back(32'(i));
            exp_pc.push_back(32'(i));
        end
        n = 0;
        while (exp_addr.size() > 1 && n < 40) begin
            cycle();
            n++;
        end
        chk1("p2_budget", n < 40, 1'b1);
        stall_D = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk1("p2_skid_no_req", imem_req, 1'b0);
        end
        stall_D = 1'b0;
        cycle();
        chk("p2_skid_PC_D", PC_D, 32'h5);
        chk1("p2_drain_no_req", imem_req, 1'b0);
        cycle();
        chk1("p2_req6", imem_req, 1'b1);
        chk("p2_addr6", imem_addr, 32'h6);
        drain_fetch("p2");

        // redirect to 0x40 while the fetch of addr 8 is outstanding
        lat = 1;
        exp_addr.push_back(32'h7);
        exp_addr.push_back(32'h8);
        exp_pc.push_back(32'h7);
        stall_F = 1'b0;
        n = 0;
        while (exp_pc.size() != 0 && n < 40) begin
            cycle();
            n++;
        end
        chk1("p3_budget", n < 40, 1'b1);
        stall_D = 1'b1;
        lat = 3;
        cycle();
        chk1("p3_valid_held", valid_D, 1'b1);
        stall_D = 1'b0;
        PC_src_D = 1'b1;
        PC_Target_D = 32'h40;
        cycle();
        PC_src_D = 1'b0;
        chk1("p3_bubble", valid_D, 1'b0);
        chk("p3_instr_nop", instr_D, NOP);
        chk("p3_PC_F", PC_F, 32'h40);
        lat = 1;
        exp_addr.push_back(32'h40);
        exp_pc.push_back(32'h40);
        cycle();
        chk1("p3_wait_no_req", imem_req, 1'b0);
        cycle();
        chk1("p3_req_target", imem_req, 1'b1);
        chk("p3_addr_target", imem_addr, 32'h40);
        drain_fetch("p3");

        // redirect to 0x80 while request for 0x42 waits for grant
        exp_addr.push_back(32'h41);
        exp_addr.push_back(32'h42);
        exp_pc.push_back(32'h41);
        stall_F = 1'b0;
        n = 0;
        while (exp_pc.size() != 0 && n < 40) begin
            cycle();
            n++;
        end
        chk1("p4_budget", n < 40, 1'b1);
        imem_gnt = 1'b0;
        PC_src_D = 1'b1;
        PC_Target_D = 32'h80;
        cycle();
        PC_src_D = 1'b0;
        chk1("p4_req_held", imem_req, 1'b1);
        chk("p4_addr_held", imem_addr, 32'h42);
        chk("p4_PC_F", PC_F, 32'h80);
        chk1("p4_bubble", valid_D, 1'b0);
        cycle();
        chk("p4_addr_held2", imem_addr, 32'h42);
        imem_gnt = 1'b1;
        exp_addr.push_back(32'h80);
        exp_pc.push_back(32'h80);
        drain_fetch("p4");

        // flush with redirect while fetch is stalled, then wrap at 0xFFFFFFFF
        flush_D = 1'b1;
        PC_src_D = 1'b1;
        PC_Target_D = 32'hFFFF_FFFF;
        cycle();
        flush_D = 1'b0;
        PC_src_D = 1'b0;
        chk1("p5_flush_valid", valid_D, 1'b0);
        chk("p5_flush_instr", instr_D, NOP);
        chk("p5_PC_F", PC_F, 32'hFFFF_FFFF);
        chk1("p5_deferred", imem_req, 1'b0);
        cycle();
        chk1("p5_deferred2", imem_req, 1'b0);
        exp_addr.push_back(32'hFFFF_FFFF);
        exp_addr.push_back(32'h0);
        exp_pc.push_back(32'hFFFF_FFFF);
        exp_pc.push_back(32'h0);
        stall_F = 1'b0;
        drain_fetch("p5");
        chk("p5_PC_F_wrap", PC_F, 32'h1);
        stall_D = 1'b1;
        flush_D = 1'b1;
        cycle();
        stall_D = 1'b0;
        flush_D = 1'b0;
        chk1("p5_flush_over_stall", valid_D, 1'b0);
        chk("p5_flush_over_stall_instr", instr_D, NOP);

        // reset while waiting; the late response must be ignored
        lat = 3;
        exp_addr.push_back(32'h1);
        stall_F = 1'b0;
        n = 0;
        while (exp_addr.size() != 0 && n < 40) begin
            cycle();
            n++;
        end
        chk1("p6_budget", n < 40, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("p6_rst_PC_F", PC_F, 32'h0);
        chk1("p6_rst_req", imem_req, 1'b0);
        chk1("p6_rst_valid", valid_D, 1'b0);
        chk("p6_rst_instr", instr_D, NOP);
        chk("p6_rst_PC_D", PC_D, 32'h0);
        lat = 1;
        exp_addr.push_back(32'h0);
        exp_pc.push_back(32'h0);
        drain_fetch("p6");

        chk("left_addr", 32'(exp_addr.size()), 32'h0);
        chk("left_instr", 32'(exp_pc.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
